// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one SPI controller.
//   One transaction is in flight at a time. The received word and a one-cycle
//   done pulse are returned to the requester that owns the transaction. A
//   watchdog aborts a transaction whose completion never arrives.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   req           per-requester request level
//   req_data      requester i word at [i*W +: W]
//   grant         one-hot owner of the current transaction
//   done          one-cycle completion pulse to the owner
//   err           qualifies done: 1 = watchdog abort
//   rx_data       last received word, valid from a done until the next done
//   enable_spi    one-cycle start strobe to the SPI controller
//   tx_byte_spi   word presented to the SPI controller
//   busy_spi      SPI controller busy (only looked at while idle)
//   complete_spi  SPI controller completion pulse
//   rx_byte_spi   SPI controller received word
module spi_bus_arbiter #(
  parameter int NUM_REQ               = 3,
  parameter int DATA_WIDTH_SPI_CONFIG = 16,
  parameter int TIMEOUT_CYCLES        = 4096
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req,
  input  logic [NUM_REQ*DATA_WIDTH_SPI_CONFIG-1:0] req_data,
  output logic [NUM_REQ-1:0]                       grant,
  output logic [NUM_REQ-1:0]                       done,
  output logic                                     err,
  output logic [DATA_WIDTH_SPI_CONFIG-1:0]         rx_data,
  output logic                                     enable_spi,
  output logic [DATA_WIDTH_SPI_CONFIG-1:0]         tx_byte_spi,
  input  logic                                     busy_spi,
  input  logic                                     complete_spi,
  input  logic [DATA_WIDTH_SPI_CONFIG-1:0]         rx_byte_spi
);

  localparam int W     = DATA_WIDTH_SPI_CONFIG;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               err_q;
  logic [W-1:0]       rx_q;
  logic               en_q;
  logic [W-1:0]       tx_q;
  logic [WD_W-1:0]    wd_q;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   owner_q;

  logic [IDX_W:0]     pick_d;
  logic [W-1:0]       sel_data_d;
  logic [NUM_REQ-1:0] sel_grant_d;

  // Returns {valid, index} of the first requester found when searching
  // upward from last+1, wrapping modulo NUM_REQ. The loop runs from the
  // farthest candidate to the nearest so the nearest one is written last.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (r[idx[IDX_W-1:0]]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  // Winner selection and its word / one-hot grant
  always_comb begin
    pick_d      = rr_pick(req, last_q);
    sel_data_d  = '0;
    sel_grant_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick_d[IDX_W-1:0]) begin
        sel_data_d     = req_data[i*W +: W];
        sel_grant_d[i] = 1'b1;
      end
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rx_q    <= '0;
      en_q    <= 1'b0;
      tx_q    <= '0;
      wd_q    <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
    end else begin
      en_q   <= 1'b0;
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (!busy_spi && pick_d[IDX_W]) begin
            state_q <= S_ISSUE;
            owner_q <= pick_d[IDX_W-1:0];
            grant_q <= sel_grant_d;
            tx_q    <= sel_data_d;
            en_q    <= 1'b1;
          end
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the same cycle as the timeout takes precedence.
          if (complete_spi) begin
            rx_q    <= rx_byte_spi;
            err_q   <= 1'b0;
            done_q  <= grant_q;
            state_q <= S_DONE;
          end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            done_q  <= grant_q;
            state_q <= S_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_DONE: begin
          last_q  <= owner_q;
          grant_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rx_data     = rx_q;
  assign enable_spi  = en_q;
  assign tx_byte_spi = tx_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter
//   Bench for spi_bus_arbiter (NUM_REQ=3, W=16, TIMEOUT_CYCLES=8). A vector
//   table drives request patterns; expected issues and completions are pushed
//   to scoreboard queues and popped when the DUT strobes enable_spi / done.
//   A small SPI controller model answers each issue after a set delay.
module tb_spi_bus_arbiter;

  localparam int NR = 3;
  localparam int W  = 16;
  localparam int T  = 8;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   done;
  logic            err;
  logic [W-1:0]    rx_data;
  logic            enable_spi;
  logic [W-1:0]    tx_byte_spi;
  logic            busy_spi;
  logic            complete_spi;
  logic [W-1:0]    rx_byte_spi;

  spi_bus_arbiter #(
    .NUM_REQ(NR),
    .DATA_WIDTH_SPI_CONFIG(W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .grant(grant),
    .done(done),
    .err(err),
    .rx_data(rx_data),
    .enable_spi(enable_spi),
    .tx_byte_spi(tx_byte_spi),
    .busy_spi(busy_spi),
    .complete_spi(complete_spi),
    .rx_byte_spi(rx_byte_spi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] grant;
    logic [W-1:0]  tx;
    logic [W-1:0]  rx;
    logic          err;
    int            lat;
  } exp_t;

  typedef struct {
    bit            rst_first;
    logic [NR-1:0] req;
    logic [NR*W-1:0] data;
    int            delay;
    bit            mute;
    int            ntx;
    logic [11:0]   order;   // 2-bit owner index per transaction, first in [1:0]
  } vec_t;

  exp_t iss_q[$];
  exp_t done_q[$];
  vec_t vecs[6];

  logic [W-1:0] rsp_word[NR];
  logic [W-1:0] model_rx;
  logic [W-1:0] resp;
  int  checks, failures;
  int  cyc, issue_cyc, cnt, spi_delay, dones_seen;
  bit  spi_mute, prev_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // One clock: advance past the edge, run the SPI model and the monitors.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    complete_spi = 1'b0;
    rx_byte_spi  = 16'hDEAD;
    if (prev_done) chk("grant_clear_after_done", 32'(grant), 32'd0);
    prev_done = (done != '0);
    if (enable_spi === 1'b1) begin
      if (iss_q.size() == 0) begin
        chk("unexpected_issue", 32'(grant), 32'd0);
      end else begin
        e = iss_q.pop_front();
        chk("issue_grant", 32'(grant), 32'(e.grant));
        chk("issue_tx", 32'(tx_byte_spi), 32'(e.tx));
      end
      issue_cyc = cyc;
      cnt = spi_delay;
      resp = 16'hDEAD;
      for (int i = 0; i < NR; i++) if (grant[i]) resp = rsp_word[i];
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0 && !spi_mute) begin
        complete_spi = 1'b1;
        rx_byte_spi  = resp;
      end
    end
    if (done != '0 && !$isunknown(done)) begin
      dones_seen++;
      if (done_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = done_q.pop_front();
        chk("done_owner", 32'(done), 32'(e.grant));
        chk("done_err", 32'(err), 32'(e.err));
        chk("done_rx", 32'(rx_data), 32'(e.rx));
        chk("done_latency", 32'(cyc - issue_cyc), 32'(e.lat));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    prev_done = 1'b0;
    cnt = 0;
    model_rx = '0;
  endtask

  task automatic run_until(input int n);
    int target;
    target = dones_seen + n;
    for (int k = 0; k < 300 && dones_seen < target; k++) step();
    if (dones_seen < target) begin
      failures++;
      checks++;
      $display("FAIL wait_for_done actual=%0d expected=%0d", dones_seen, target);
    end
  endtask

  task automatic push_exp(input int idx, input logic [W-1:0] tx, input bit mute,
                          input int delay);
    exp_t e;
    e.grant = NR'(1) << idx;
    e.tx    = tx;
    if (mute) begin
      e.err = 1'b1;
      e.rx  = model_rx;
      e.lat = T + 1;
    end else begin
      e.err = 1'b0;
      e.rx  = rsp_word[idx];
      model_rx = e.rx;
      e.lat = (delay >= T) ? T + 1 : delay + 1;
    end
    iss_q.push_back(e);
    done_q.push_back(e);
  endtask

  initial begin
    logic [11:0]   ord;
    logic [NR*W-1:0] d;
    int idx;
    checks = 0; failures = 0; cyc = 0; cnt = 0; dones_seen = 0;
    prev_done = 1'b0; spi_mute = 1'b0; spi_delay = 3;
    rsp_word[0] = 16'h5A01; rsp_word[1] = 16'h00AB; rsp_word[2] = 16'hC3D2;
    model_rx = '0; resp = '0;
    rst = 1'b1; req = '0; req_data = '0; busy_spi = 1'b0;
    complete_spi = 1'b0; rx_byte_spi = 16'hDEAD;

    vecs[0] = '{rst_first:1'b1, req:3'b010, data:{16'h0000, 16'hF4E3, 16'h0000},
                delay:5, mute:1'b0, ntx:1, order:12'h001};
    vecs[1] = '{rst_first:1'b1, req:3'b111, data:{16'hC3C3, 16'hB2B2, 16'hA1A1},
                delay:3, mute:1'b0, ntx:6, order:12'h924};
    vecs[2] = '{rst_first:1'b0, req:3'b001, data:{16'h0000, 16'h0000, 16'h1234},
                delay:3, mute:1'b1, ntx:1, order:12'h000};
    vecs[3] = '{rst_first:1'b0, req:3'b100, data:{16'h5678, 16'h0000, 16'h0000},
                delay:5, mute:1'b0, ntx:1, order:12'h002};
    vecs[4] = '{rst_first:1'b0, req:3'b010, data:{16'h0000, 16'h9ABC, 16'h0000},
                delay:T, mute:1'b0, ntx:1, order:12'h001};
    vecs[5] = '{rst_first:1'b0, req:3'b001, data:{16'h0000, 16'h0000, 16'hDEF0},
                delay:2, mute:1'b0, ntx:1, order:12'h000};

    do_reset();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rx", 32'(rx_data), 32'd0);
    chk("reset_enable", 32'(enable_spi), 32'd0);
    chk("reset_tx", 32'(tx_byte_spi), 32'd0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].rst_first) do_reset();
      spi_delay = vecs[v].delay;
      spi_mute  = vecs[v].mute;
      req_data  = vecs[v].data;
      ord = vecs[v].order;
      d   = vecs[v].data;
      for (int t = 0; t < vecs[v].ntx; t++) begin
        idx = int'(ord[t*2 +: 2]);
        push_exp(idx, d[idx*W +: W], vecs[v].mute, vecs[v].delay);
      end
      req = vecs[v].req;
      run_until(vecs[v].ntx);
      req = '0;
      step();
      step();
    end

    // Busy gating: no issue while the controller is busy, issue one cycle after.
    spi_mute = 1'b0; spi_delay = 4;
    busy_spi = 1'b1;
    req_data = {16'h0000, 16'h0000, 16'h3C5A};
    push_exp(0, 16'h3C5A, 1'b0, 4);
    req = 3'b001;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("busy_no_enable", 32'(enable_spi), 32'd0);
    end
    busy_spi = 1'b0;
    step();
    chk("busy_release_enable", 32'(enable_spi), 32'd1);
    run_until(1);
    req = '0;
    step();
    step();

    // Reset during WAIT: outputs clear, no done, requester 0 wins next.
    spi_mute = 1'b1; spi_delay = 20;
    req_data = {16'h7E81, 16'h0000, 16'h9B10};
    begin
      exp_t e;
      e.grant = 3'b100; e.tx = 16'h7E81; e.rx = '0; e.err = 1'b0; e.lat = 0;
      iss_q.push_back(e);
    end
    req = 3'b100;
    for (int k = 0; k < 10 && iss_q.size() != 0; k++) step();
    chk("midwait_issued", 32'(iss_q.size()), 32'd0);
    step(); step(); step();
    rst = 1'b1;
    req = 3'b101;
    step();
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_rx", 32'(rx_data), 32'd0);
    chk("midrst_enable", 32'(enable_spi), 32'd0);
    chk("midrst_tx", 32'(tx_byte_spi), 32'd0);
    rst = 1'b0;
    cnt = 0; spi_mute = 1'b0; spi_delay = 3; model_rx = '0; prev_done = 1'b0;
    push_exp(0, 16'h9B10, 1'b0, 3);
    run_until(1);
    req = '0;
    step();
    step();

    chk("scoreboard_drained", 32'(iss_q.size() + done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
